mem_port_arbiter: RTL and testbench

- Arbitrates the single unified memory port between instruction fetch (IF) and the load/store unit (LSU) in the 5-stage core.
- Sequences each access as grant → wait for memory response → return data to the winner.
- Handles flush squashing of in-flight fetches and a memory timeout.
- Sits between Fetch/LSU and the memory model, so the two stages never drive the memory bus at the same time.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_arb_timeout_counter.sv | 34 +++
 rtl/mem_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and constants for the unified memory port arbiter.
//   arb_state_e  : arbiter sequencing states (idle / waiting / responding)
//   arb_owner_e  : which requester owns the in-flight memory access
//   ARB_ERR_DATA : default read data returned when the memory times out
//   ARB_BE_WORD  : full-word byte enable used for instruction fetches
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;
  localparam logic [3:0]  ARB_BE_WORD  = 4'hF;

endpackage

// File: rtl/mem_arb_timeout_counter.sv
// mem_arb_timeout_counter
//   Clear/enable up-counter that flags when it has reached TIMEOUT-1.
//   clock    : core clock
//   reset    : synchronous active-high reset
//   clear    : force the count to zero (has priority over enable)
//   enable   : advance the count by one
//   terminal : count == TIMEOUT-1
module mem_arb_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      // Holding at LAST keeps a non power-of-two TIMEOUT from wrapping.
      count_reg <= count_reg + 1'b1;
    end
  end

  assign terminal = (count_reg == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single unified memory port between instruction fetch (IF)
//   and the load/store unit (LSU). Each access is sequenced as
//   grant (IDLE) -> wait for mem_rvalid_ip (BUSY) -> return data (RESP).
//
//   Optional build macro MEM_ARB_RR_EN:
//     defined   : round-robin between IF and LSU on contention
//     undefined : fixed LSU priority (IF may starve behind back-to-back LSU)
//
//   Ports
//     clock, reset             : core clock, synchronous active-high reset
//     flush_ip                 : pipeline flush, squashes fetch traffic
//     if_req_ip/if_addr_ip     : fetch request, held until if_gnt_op
//     if_gnt_op                : fetch accepted this cycle (combinational)
//     if_rvalid_op/if_rdata_op : one-cycle fetch data return
//     lsu_req_ip/we/be/addr/wdata : LSU request, held until lsu_gnt_op
//     lsu_gnt_op               : LSU accepted this cycle (combinational)
//     lsu_rvalid_op/lsu_rdata_op : one-cycle load data / store ack (data 0)
//     mem_req_op/we/be/addr/wdata : one-cycle memory request, bus driven
//                                 only in the grant cycle, zero otherwise
//     mem_rvalid_ip/mem_rdata_ip : memory response for reads and writes
//     err_op                   : one-cycle pulse with a timed-out response
//
//   A transaction with no response spends exactly TIMEOUT cycles in BUSY
//   before returning ERR_DATA.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ARB_ERR_DATA
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_ip,
  input  logic        if_req_ip,
  input  logic [31:0] if_addr_ip,
  output logic        if_gnt_op,
  output logic        if_rvalid_op,
  output logic [31:0] if_rdata_op,
  input  logic        lsu_req_ip,
  input  logic        lsu_we_ip,
  input  logic [3:0]  lsu_be_ip,
  input  logic [31:0] lsu_addr_ip,
  input  logic [31:0] lsu_wdata_ip,
  output logic        lsu_gnt_op,
  output logic        lsu_rvalid_op,
  output logic [31:0] lsu_rdata_op,
  output logic        mem_req_op,
  output logic        mem_we_op,
  output logic [3:0]  mem_be_op,
  output logic [31:0] mem_addr_op,
  output logic [31:0] mem_wdata_op,
  input  logic        mem_rvalid_ip,
  input  logic [31:0] mem_rdata_ip,
  output logic        err_op
);

  arb_state_e  state_reg, state_next;
  arb_owner_e  owner_reg;
  logic        store_reg;
  logic        squash_reg;
  logic        err_reg;
  logic [31:0] if_rdata_reg;
  logic [31:0] lsu_rdata_reg;

  logic if_eff;
  logic pick_lsu;
  logic can_grant;
  logic grant_if;
  logic grant_lsu;
  logic in_busy;
  logic in_resp;
  logic timeout_tc;

  // A fetch raised in the same cycle as a flush is already on the wrong path.
  assign if_eff = if_req_ip & ~flush_ip;

`ifdef MEM_ARB_RR_EN
  arb_owner_e last_owner_reg;

  // On contention, the side that did not win last time goes first.
  assign pick_lsu = lsu_req_ip & (~if_eff | (last_owner_reg == OWN_IF));

  always_ff @(posedge clock) begin
    if (reset) begin
      last_owner_reg <= OWN_IF;
    end else if (grant_lsu) begin
      last_owner_reg <= OWN_LSU;
    end else if (grant_if) begin
      last_owner_reg <= OWN_IF;
    end
  end
`else
  // LSU carries the older instruction, so it always wins.
  assign pick_lsu = lsu_req_ip;
`endif

  // Grants are suppressed while reset is held so no request leaks out.
  assign can_grant = (state_reg == ARB_IDLE) & ~reset;
  assign grant_lsu = can_grant & pick_lsu;
  assign grant_if  = can_grant & if_eff & ~pick_lsu;
  assign in_busy   = (state_reg == ARB_BUSY);
  assign in_resp   = (state_reg == ARB_RESP);

  mem_arb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear    (~in_busy),
    .enable   (in_busy),
    .terminal (timeout_tc)
  );

  // Memory bus is only non-zero in the grant cycle.
  always_comb begin
    mem_req_op   = grant_if | grant_lsu;
    mem_we_op    = 1'b0;
    mem_be_op    = '0;
    mem_addr_op  = '0;
    mem_wdata_op = '0;
    if (grant_lsu) begin
      mem_we_op    = lsu_we_ip;
      mem_be_op    = lsu_be_ip;
      mem_addr_op  = lsu_addr_ip;
      mem_wdata_op = lsu_wdata_ip;
    end else if (grant_if) begin
      mem_be_op   = ARB_BE_WORD;
      mem_addr_op = if_addr_ip;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ARB_IDLE: if (grant_if || grant_lsu) state_next = ARB_BUSY;
      // A response arriving on the terminal cycle wins over the timeout.
      ARB_BUSY: if (mem_rvalid_ip || timeout_tc) state_next = ARB_RESP;
      ARB_RESP: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ARB_IDLE;
      owner_reg     <= OWN_IF;
      store_reg     <= 1'b0;
      squash_reg    <= 1'b0;
      err_reg       <= 1'b0;
      if_rdata_reg  <= '0;
      lsu_rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      unique case (state_reg)
        ARB_IDLE: begin
          if (grant_lsu) begin
            owner_reg <= OWN_LSU;
            store_reg <= lsu_we_ip;
          end else if (grant_if) begin
            owner_reg <= OWN_IF;
            store_reg <= 1'b0;
          end
        end
        ARB_BUSY: begin
          if (flush_ip && (owner_reg == OWN_IF)) begin
            squash_reg <= 1'b1;
          end
          if (mem_rvalid_ip) begin
            // A squashed fetch still consumes (and captures) its response.
            if (owner_reg == OWN_LSU) begin
              lsu_rdata_reg <= store_reg ? '0 : mem_rdata_ip;
            end else begin
              if_rdata_reg <= mem_rdata_ip;
            end
          end else if (timeout_tc) begin
            err_reg <= 1'b1;
            if (owner_reg == OWN_LSU) begin
              lsu_rdata_reg <= ERR_DATA;
            end else begin
              if_rdata_reg <= ERR_DATA;
            end
          end
        end
        ARB_RESP: begin
          squash_reg <= 1'b0;
          err_reg    <= 1'b0;
        end
        default: begin
          squash_reg <= 1'b0;
          err_reg    <= 1'b0;
        end
      endcase
    end
  end

  // A flush landing in the response cycle itself also drops the fetch.
  assign if_rvalid_op  = in_resp & (owner_reg == OWN_IF) & ~squash_reg & ~flush_ip;
  assign lsu_rvalid_op = in_resp & (owner_reg == OWN_LSU);
  assign err_op        = in_resp & err_reg;
  assign if_gnt_op     = grant_if;
  assign lsu_gnt_op    = grant_lsu;
  assign if_rdata_op   = if_rdata_reg;
  assign lsu_rdata_op  = lsu_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. Inputs change 1 ns after the
//   rising edge and outputs are sampled 1 ns later. The reference model
//   tracks who should win each idle cycle and what data each side should
//   see, from the arbitration rules alone.
module tb_mem_port_arbiter;

  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic        clock;
  logic        reset;
  logic        flush_ip;
  logic        if_req_ip;
  logic [31:0] if_addr_ip;
  logic        if_gnt_op;
  logic        if_rvalid_op;
  logic [31:0] if_rdata_op;
  logic        lsu_req_ip;
  logic        lsu_we_ip;
  logic [3:0]  lsu_be_ip;
  logic [31:0] lsu_addr_ip;
  logic [31:0] lsu_wdata_ip;
  logic        lsu_gnt_op;
  logic        lsu_rvalid_op;
  logic [31:0] lsu_rdata_op;
  logic        mem_req_op;
  logic        mem_we_op;
  logic [3:0]  mem_be_op;
  logic [31:0] mem_addr_op;
  logic [31:0] mem_wdata_op;
  logic        mem_rvalid_ip;
  logic [31:0] mem_rdata_ip;
  logic        err_op;

  mem_port_arbiter #(
    .TIMEOUT  (TIMEOUT),
    .ERR_DATA (ERR_DATA)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .flush_ip      (flush_ip),
    .if_req_ip     (if_req_ip),
    .if_addr_ip    (if_addr_ip),
    .if_gnt_op     (if_gnt_op),
    .if_rvalid_op  (if_rvalid_op),
    .if_rdata_op   (if_rdata_op),
    .lsu_req_ip    (lsu_req_ip),
    .lsu_we_ip     (lsu_we_ip),
    .lsu_be_ip     (lsu_be_ip),
    .lsu_addr_ip   (lsu_addr_ip),
    .lsu_wdata_ip  (lsu_wdata_ip),
    .lsu_gnt_op    (lsu_gnt_op),
    .lsu_rvalid_op (lsu_rvalid_op),
    .lsu_rdata_op  (lsu_rdata_op),
    .mem_req_op    (mem_req_op),
    .mem_we_op     (mem_we_op),
    .mem_be_op     (mem_be_op),
    .mem_addr_op   (mem_addr_op),
    .mem_wdata_op  (mem_wdata_op),
    .mem_rvalid_ip (mem_rvalid_ip),
    .mem_rdata_ip  (mem_rdata_ip),
    .err_op        (err_op)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit          model_last_lsu;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_lsu_rdata;

  // Who should win an idle cycle, given the (effective) requests.
  function automatic bit lsu_wins(bit if_req, bit lsu_req);
    if (!lsu_req) return 1'b0;
    if (!if_req)  return 1'b1;
`ifdef MEM_ARB_RR_EN
    return !model_last_lsu;
`else
    return 1'b1;
`endif
  endfunction

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    flush_ip      = 1'b0;
    if_req_ip     = 1'b0;
    if_addr_ip    = '0;
    lsu_req_ip    = 1'b0;
    lsu_we_ip     = 1'b0;
    lsu_be_ip     = '0;
    lsu_addr_ip   = '0;
    lsu_wdata_ip  = '0;
    mem_rvalid_ip = 1'b0;
    mem_rdata_ip  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) advance();
    #1;
    n_checks++; if ({if_gnt_op, lsu_gnt_op, if_rvalid_op, lsu_rvalid_op, mem_req_op, err_op, mem_we_op} !== 7'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b required 0", {if_gnt_op, lsu_gnt_op, if_rvalid_op, lsu_rvalid_op, mem_req_op, err_op, mem_we_op}); end
    n_checks++; if ({if_rdata_op, lsu_rdata_op} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", {if_rdata_op, lsu_rdata_op}); end
    n_checks++; if ({mem_be_op, mem_addr_op, mem_wdata_op} !== 68'h0) begin n_fail++; $display("FAIL reset_bus: got %h required 0", {mem_be_op, mem_addr_op, mem_wdata_op}); end
    advance();
    if_req_ip = 1'b1; lsu_req_ip = 1'b1; if_addr_ip = 32'h40;
    #1;
    n_checks++; if ({if_gnt_op, lsu_gnt_op, mem_req_op} !== 3'b0) begin n_fail++; $display("FAIL reset_gnt: got %b required 000", {if_gnt_op, lsu_gnt_op, mem_req_op}); end
    advance();
    reset = 1'b0;
    idle_inputs();
    #1;
    n_checks++; if ({if_gnt_op, lsu_gnt_op, if_rvalid_op, lsu_rvalid_op, mem_req_op, err_op} !== 6'b0) begin n_fail++; $display("FAIL reset_release: got %b required 0", {if_gnt_op, lsu_gnt_op, if_rvalid_op, lsu_rvalid_op, mem_req_op, err_op}); end
    model_last_lsu = 1'b0;
    exp_if_rdata   = '0;
    exp_lsu_rdata  = '0;
    $display("txn reset: arbiter reset, last_lsu=%0d", model_last_lsu);
  endtask

  task automatic test_if_read();
    advance();
    if_req_ip = 1'b1; if_addr_ip = 32'h100;
    #1;
    n_checks++; if ({if_gnt_op, lsu_gnt_op, mem_req_op} !== 3'b101) begin n_fail++; $display("FAIL ifrd_gnt: got %b required 101", {if_gnt_op, lsu_gnt_op, mem_req_op}); end
    n_checks++; if ({mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op} !== {1'b0, 4'hF, 32'h100, 32'h0}) begin n_fail++; $display("FAIL ifrd_bus: got %h required %h", {mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op}, {1'b0, 4'hF, 32'h100, 32'h0}); end
    model_last_lsu = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      advance();
      if_req_ip     = 1'b0;
      mem_rvalid_ip = (c == 3);
      mem_rdata_ip  = (c == 3) ? 32'h0050_0093 : 32'h0;
      #1;
      n_checks++; if ({if_rvalid_op, lsu_rvalid_op, lsu_gnt_op, if_gnt_op, mem_req_op} !== {(c == 4), 4'b0}) begin n_fail++; $display("FAIL ifrd_cycle%0d: got %b required %b", c, {if_rvalid_op, lsu_rvalid_op, lsu_gnt_op, if_gnt_op, mem_req_op}, {(c == 4), 4'b0}); end
    end
    n_checks++; if (if_rdata_op !== 32'h0050_0093) begin n_fail++; $display("FAIL ifrd_data: got %h required 00500093", if_rdata_op); end
    exp_if_rdata = 32'h0050_0093;
    advance();
    #1;
    n_checks++; if (if_rvalid_op !== 1'b0) begin n_fail++; $display("FAIL ifrd_pulse: got %b required 0", if_rvalid_op); end
    $display("txn if_read: addr=00000100 data=%h", if_rdata_op);
  endtask

  task automatic test_simultaneous();
    bit ip, lp, wl;
    int n_grants;
    logic [31:0] data;
`ifdef MEM_ARB_RR_EN
    n_grants = 4;
`else
    n_grants = 2;
`endif
    ip = 1'b1; lp = 1'b1;
    for (int g = 0; g < n_grants; g++) begin
      advance();
      if_req_ip = ip; if_addr_ip = 32'h104;
      lsu_req_ip = lp; lsu_we_ip = 1'b0; lsu_be_ip = 4'hF; lsu_addr_ip = 32'h2000;
      mem_rvalid_ip = 1'b0;
      #1;
      wl = lsu_wins(ip, lp);
      n_checks++; if ({if_gnt_op, lsu_gnt_op} !== {!wl, wl}) begin n_fail++; $display("FAIL simul_gnt%0d: got %b required %b", g, {if_gnt_op, lsu_gnt_op}, {!wl, wl}); end
      n_checks++; if (mem_addr_op !== (wl ? 32'h2000 : 32'h104)) begin n_fail++; $display("FAIL simul_addr%0d: got %h required %h", g, mem_addr_op, (wl ? 32'h2000 : 32'h104)); end
      model_last_lsu = wl;
      if (wl) lp = 1'b0; else ip = 1'b0;
      data = $urandom;
      advance();
      if_req_ip = ip; lsu_req_ip = lp;
      mem_rvalid_ip = 1'b1; mem_rdata_ip = data;
      #1;
      n_checks++; if ({if_gnt_op, lsu_gnt_op, mem_req_op} !== 3'b0) begin n_fail++; $display("FAIL simul_busy%0d: got %b required 000", g, {if_gnt_op, lsu_gnt_op, mem_req_op}); end
      advance();
      mem_rvalid_ip = 1'b0;
      #1;
      if (wl) exp_lsu_rdata = data; else exp_if_rdata = data;
      n_checks++; if ({if_rvalid_op, lsu_rvalid_op} !== {!wl, wl}) begin n_fail++; $display("FAIL simul_rvalid%0d: got %b required %b", g, {if_rvalid_op, lsu_rvalid_op}, {!wl, wl}); end
      n_checks++; if ({if_rdata_op, lsu_rdata_op} !== {exp_if_rdata, exp_lsu_rdata}) begin n_fail++; $display("FAIL simul_rdata%0d: got %h required %h", g, {if_rdata_op, lsu_rdata_op}, {exp_if_rdata, exp_lsu_rdata}); end
      $display("txn simultaneous %0d: winner=%s data=%h", g, wl ? "LSU" : "IF", data);
`ifdef MEM_ARB_RR_EN
      // Both sides keep requesting back-to-back.
      if (wl) lp = 1'b1; else ip = 1'b1;
`endif
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_store();
    lsu_req_ip = 1'b1; lsu_we_ip = 1'b1; lsu_addr_ip = 32'h2004;
    lsu_wdata_ip = 32'hCAFE_F00D; lsu_be_ip = 4'hF;
    #1;
    n_checks++; if ({lsu_gnt_op, if_gnt_op, mem_req_op} !== 3'b101) begin n_fail++; $display("FAIL store_gnt: got %b required 101", {lsu_gnt_op, if_gnt_op, mem_req_op}); end
    n_checks++; if ({mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op} !== {1'b1, 4'hF, 32'h2004, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL store_bus: got %h required %h", {mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op}, {1'b1, 4'hF, 32'h2004, 32'hCAFE_F00D}); end
    model_last_lsu = 1'b1;
    advance();
    lsu_req_ip = 1'b0; lsu_we_ip = 1'b0;
    mem_rvalid_ip = 1'b1; mem_rdata_ip = 32'h1234_5678;
    #1;
    n_checks++; if (lsu_rvalid_op !== 1'b0) begin n_fail++; $display("FAIL store_early: got %b required 0", lsu_rvalid_op); end
    advance();
    mem_rvalid_ip = 1'b0;
    #1;
    exp_lsu_rdata = '0;
    n_checks++; if ({lsu_rvalid_op, lsu_rdata_op} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL store_ack: got %h required %h", {lsu_rvalid_op, lsu_rdata_op}, {1'b1, 32'h0}); end
    $display("txn store: addr=00002004 wdata=cafef00d ack_rdata=%h", lsu_rdata_op);
  endtask

  task automatic test_flush();
    advance();
    if_req_ip = 1'b1; if_addr_ip = 32'h108; flush_ip = 1'b1;
    #1;
    n_checks++; if ({if_gnt_op, mem_req_op} !== 2'b00) begin n_fail++; $display("FAIL flush_idle: got %b required 00", {if_gnt_op, mem_req_op}); end
    advance();
    flush_ip = 1'b0;
    #1;
    n_checks++; if (if_gnt_op !== 1'b1) begin n_fail++; $display("FAIL flush_gnt: got %b required 1", if_gnt_op); end
    model_last_lsu = 1'b0;
    advance();
    if_req_ip = 1'b0; flush_ip = 1'b1;
    advance();
    flush_ip = 1'b0; mem_rvalid_ip = 1'b1; mem_rdata_ip = 32'h1111_1111;
    #1;
    n_checks++; if (if_rvalid_op !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b required 0", if_rvalid_op); end
    advance();
    mem_rvalid_ip = 1'b0;
    #1;
    exp_if_rdata = 32'h1111_1111;
    n_checks++; if ({if_rvalid_op, lsu_rvalid_op} !== 2'b00) begin n_fail++; $display("FAIL flush_squash: got %b required 00", {if_rvalid_op, lsu_rvalid_op}); end
    advance();
    if_req_ip = 1'b1; if_addr_ip = 32'h10C;
    #1;
    n_checks++; if ({if_gnt_op, mem_addr_op} !== {1'b1, 32'h10C}) begin n_fail++; $display("FAIL flush_next_gnt: got %h required %h", {if_gnt_op, mem_addr_op}, {1'b1, 32'h10C}); end
    model_last_lsu = 1'b0;
    advance();
    if_req_ip = 1'b0; mem_rvalid_ip = 1'b1; mem_rdata_ip = 32'h2222_2222;
    advance();
    mem_rvalid_ip = 1'b0;
    #1;
    exp_if_rdata = 32'h2222_2222;
    n_checks++; if ({if_rvalid_op, if_rdata_op} !== {1'b1, 32'h2222_2222}) begin n_fail++; $display("FAIL flush_next_data: got %h required %h", {if_rvalid_op, if_rdata_op}, {1'b1, 32'h2222_2222}); end
    $display("txn flush: squashed fetch 00000108, then fetch 0000010c data=%h", if_rdata_op);
  endtask

  task automatic test_timeout();
    bit early;
    // No response at all: TIMEOUT waiting cycles, then an error response.
    advance();
    lsu_req_ip = 1'b1; lsu_we_ip = 1'b0; lsu_be_ip = 4'hF; lsu_addr_ip = 32'h3000;
    #1;
    n_checks++; if (lsu_gnt_op !== 1'b1) begin n_fail++; $display("FAIL tmo_gnt: got %b required 1", lsu_gnt_op); end
    model_last_lsu = 1'b1;
    early = 1'b0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      advance();
      lsu_req_ip = 1'b0;
      #1;
      if ({lsu_rvalid_op, err_op, lsu_gnt_op, if_gnt_op} !== 4'b0) early = 1'b1;
    end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b required 0", early); end
    advance();
    #1;
    exp_lsu_rdata = ERR_DATA;
    n_checks++; if ({err_op, lsu_rvalid_op, lsu_rdata_op} !== {2'b11, ERR_DATA}) begin n_fail++; $display("FAIL tmo_resp: got %h required %h", {err_op, lsu_rvalid_op, lsu_rdata_op}, {2'b11, ERR_DATA}); end
    advance();
    #1;
    n_checks++; if ({err_op, lsu_rvalid_op} !== 2'b00) begin n_fail++; $display("FAIL tmo_pulse: got %b required 00", {err_op, lsu_rvalid_op}); end
    $display("txn timeout: addr=00003000 rdata=%h", lsu_rdata_op);

    // Response on the very last waiting cycle beats the timeout.
    lsu_req_ip = 1'b1; lsu_addr_ip = 32'h3008;
    #1;
    model_last_lsu = 1'b1;
    for (int c = 1; c <= TIMEOUT; c++) begin
      advance();
      lsu_req_ip = 1'b0;
      mem_rvalid_ip = (c == TIMEOUT); mem_rdata_ip = 32'h0000_ABCD;
    end
    advance();
    mem_rvalid_ip = 1'b0;
    #1;
    exp_lsu_rdata = 32'h0000_ABCD;
    n_checks++; if ({err_op, lsu_rvalid_op, lsu_rdata_op} !== {2'b01, 32'h0000_ABCD}) begin n_fail++; $display("FAIL tmo_race: got %h required %h", {err_op, lsu_rvalid_op, lsu_rdata_op}, {2'b01, 32'h0000_ABCD}); end
    $display("txn timeout_race: addr=00003008 rdata=%h", lsu_rdata_op);

    // Reset in the middle of a transaction.
    advance();
    lsu_req_ip = 1'b1; lsu_addr_ip = 32'h3004;
    #1;
    n_checks++; if (lsu_gnt_op !== 1'b1) begin n_fail++; $display("FAIL rst_busy_gnt: got %b required 1", lsu_gnt_op); end
    advance();
    lsu_req_ip = 1'b0;
    advance();
    reset = 1'b1;
    advance();
    reset = 1'b0;
    #1;
    model_last_lsu = 1'b0;
    exp_if_rdata   = '0;
    exp_lsu_rdata  = '0;
    n_checks++; if ({if_gnt_op, lsu_gnt_op, if_rvalid_op, lsu_rvalid_op, mem_req_op, err_op, mem_we_op} !== 7'b0) begin n_fail++; $display("FAIL rst_busy_ctrl: got %b required 0", {if_gnt_op, lsu_gnt_op, if_rvalid_op, lsu_rvalid_op, mem_req_op, err_op, mem_we_op}); end
    n_checks++; if ({if_rdata_op, lsu_rdata_op, mem_be_op, mem_addr_op, mem_wdata_op} !== 132'h0) begin n_fail++; $display("FAIL rst_busy_data: got %h required 0", {if_rdata_op, lsu_rdata_op, mem_be_op, mem_addr_op, mem_wdata_op}); end
    advance();
    mem_rvalid_ip = 1'b1; mem_rdata_ip = 32'h5555_5555;
    advance();
    mem_rvalid_ip = 1'b0;
    #1;
    n_checks++; if ({if_rvalid_op, lsu_rvalid_op, err_op, lsu_rdata_op} !== 35'h0) begin n_fail++; $display("FAIL rst_late_rvalid: got %h required 0", {if_rvalid_op, lsu_rvalid_op, err_op, lsu_rdata_op}); end
    $display("txn reset_in_busy: aborted addr=00003004");
  endtask

  task automatic test_random();
    bit ip, lp, lw, wl, fl, squashed, bad;
    logic [31:0] ia, la, lwd, data;
    logic [3:0]  lbe;
    int lat, fl_at;
    ip = 1'b0; lp = 1'b0; lw = 1'b0;
    ia = '0; la = '0; lwd = '0; lbe = 4'hF;
    for (int r = 0; r < 40; r++) begin
      if (!ip && ($urandom_range(0, 1) == 1)) begin ip = 1'b1; ia = $urandom; end
      if (!lp && ($urandom_range(0, 1) == 1)) begin
        lp = 1'b1; la = $urandom; lw = ($urandom_range(0, 1) == 1);
        lbe = 4'($urandom_range(1, 15)); lwd = $urandom;
      end
      if (!ip && !lp) begin ip = 1'b1; ia = $urandom; end
      advance();
      flush_ip = 1'b0; mem_rvalid_ip = 1'b0;
      if_req_ip = ip; if_addr_ip = ia;
      lsu_req_ip = lp; lsu_we_ip = lw; lsu_be_ip = lbe; lsu_addr_ip = la; lsu_wdata_ip = lwd;
      #1;
      wl = lsu_wins(ip, lp);
      n_checks++; if ({if_gnt_op, lsu_gnt_op, mem_req_op} !== {!wl, wl, 1'b1}) begin n_fail++; $display("FAIL rand_gnt%0d: got %b required %b", r, {if_gnt_op, lsu_gnt_op, mem_req_op}, {!wl, wl, 1'b1}); end
      n_checks++; if ({mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op} !== (wl ? {lw, lbe, la, lwd} : {1'b0, 4'hF, ia, 32'h0})) begin n_fail++; $display("FAIL rand_bus%0d: got %h required %h", r, {mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op}, (wl ? {lw, lbe, la, lwd} : {1'b0, 4'hF, ia, 32'h0})); end
      model_last_lsu = wl;
      if (wl) lp = 1'b0; else ip = 1'b0;
      lat      = $urandom_range(1, 6);
      data     = $urandom;
      fl       = ($urandom_range(0, 3) == 0);
      fl_at    = $urandom_range(1, lat);
      squashed = !wl && fl;
      bad      = 1'b0;
      for (int c = 1; c <= lat; c++) begin
        advance();
        if_req_ip = ip; lsu_req_ip = lp;
        flush_ip = fl && (c == fl_at);
        mem_rvalid_ip = (c == lat); mem_rdata_ip = data;
        #1;
        if ({if_gnt_op, lsu_gnt_op, mem_req_op, if_rvalid_op, lsu_rvalid_op, err_op} !== 6'b0) bad = 1'b1;
      end
      n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rand_busy%0d: got %b required 0", r, bad); end
      advance();
      flush_ip = 1'b0; mem_rvalid_ip = 1'b0;
      #1;
      if (wl) exp_lsu_rdata = (wl && lw) ? 32'h0 : data;
      else    exp_if_rdata  = data;
      n_checks++; if ({if_rvalid_op, lsu_rvalid_op, err_op} !== {!wl && !squashed, wl, 1'b0}) begin n_fail++; $display("FAIL rand_rvalid%0d: got %b required %b", r, {if_rvalid_op, lsu_rvalid_op, err_op}, {!wl && !squashed, wl, 1'b0}); end
      n_checks++; if ({if_rdata_op, lsu_rdata_op} !== {exp_if_rdata, exp_lsu_rdata}) begin n_fail++; $display("FAIL rand_rdata%0d: got %h required %h", r, {if_rdata_op, lsu_rdata_op}, {exp_if_rdata, exp_lsu_rdata}); end
      $display("txn rand %0d: winner=%s we=%0d lat=%0d flush=%0d last_lsu=%0d data=%h", r, wl ? "LSU" : "IF", wl && lw, lat, fl, model_last_lsu, data);
    end
    advance();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_last_lsu = 1'b0;
    exp_if_rdata   = '0;
    exp_lsu_rdata  = '0;
    test_reset();
    test_if_read();
    test_simultaneous();
    test_store();
    test_flush();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
